// File: rtl/kaipokrandt_bus_ctrl.sv
// kaipokrandt_bus_ctrl: round-robin arbiter and sequencer for register-to-register transfers on the shared tristate bus
module kaipokrandt_bus_ctrl #(
    parameter int NREG = 4,
    parameter int IW = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req0,
    input  logic [IW-1:0]   src0,
    input  logic [IW-1:0]   dst0,
    input  logic            ext0,
    output logic            gnt0,
    input  logic            req1,
    input  logic [IW-1:0]   src1,
    input  logic [IW-1:0]   dst1,
    input  logic            ext1,
    output logic            gnt1,
    output logic [NREG-1:0] drv_en,
    output logic [NREG-1:0] ld_en,
    output logic            extout_en,
    output logic            busy,
    output logic            err
);
    typedef enum logic [1:0] {IDLE, DRIVE, LOAD, DONE} state_t;
    localparam logic [IW:0] NREG_W = (IW+1)'(NREG);
    localparam logic [NREG-1:0] ONE = NREG'(1);
    state_t state, state_nxt;
    logic [IW-1:0] src_q, dst_q, src_w, dst_w;
    logic ext_q, id_q, err_q, ptr, extout_hold;
    logic pick, ext_w, bad_w, any_req;
    always_comb begin
        any_req = req0 || req1;
        pick = (req0 && req1) ? ptr : req1;
        src_w = pick ? src1 : src0;
        dst_w = pick ? dst1 : dst0;
        ext_w = pick ? ext1 : ext0;
        bad_w = (src_w == dst_w) || ({1'b0, src_w} >= NREG_W) || ({1'b0, dst_w} >= NREG_W);
        state_nxt = state;
        case (state)
            IDLE:  state_nxt = any_req ? (bad_w ? DONE : DRIVE) : IDLE;
            DRIVE: state_nxt = LOAD;
            LOAD:  state_nxt = DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end
    // Outputs depend only on registered state and latched fields.
    always_comb begin
        drv_en = (state == DRIVE || state == LOAD) ? ONE << src_q : '0;
        ld_en = (state == LOAD) ? ONE << dst_q : '0;
        gnt0 = (state == DONE) && !id_q;
        gnt1 = (state == DONE) && id_q;
        err = (state == DONE) && err_q;
        busy = state != IDLE;
        extout_en = extout_hold;
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            src_q <= '0;
            dst_q <= '0;
            ext_q <= 1'b0;
            id_q <= 1'b0;
            err_q <= 1'b0;
            ptr <= 1'b0;
            extout_hold <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && any_req) begin
                src_q <= src_w;
                dst_q <= dst_w;
                ext_q <= ext_w;
                id_q <= pick;
                err_q <= bad_w;
            end
            if (state == LOAD && dst_q == '0)
                extout_hold <= ext_q;
            if (state == DONE)
                ptr <= ~id_q;
        end
    end
endmodule

// File: tb/tb_kaipokrandt_bus_ctrl.sv
// tb_kaipokrandt_bus_ctrl: directed checks of arbitration, sequencing, extout, errors and reset abort
module tb_kaipokrandt_bus_ctrl;
    logic clk = 1'b0, reset = 1'b0;
    logic req0 = 1'b0, req1 = 1'b0, ext0 = 1'b0, ext1 = 1'b0, r3 = 1'b0;
    logic [1:0] src0 = '0, dst0 = '0, src1 = '0, dst1 = '0;
    logic gnt0, gnt1, extout_en, busy, err;
    logic [3:0] drv_en, ld_en;
    logic g3a, g3b, x3, b3, e3;
    logic [2:0] d3, l3;
    int checks = 0, errors = 0;

    kaipokrandt_bus_ctrl dut (
        .clk(clk), .reset(reset),
        .req0(req0), .src0(src0), .dst0(dst0), .ext0(ext0), .gnt0(gnt0),
        .req1(req1), .src1(src1), .dst1(dst1), .ext1(ext1), .gnt1(gnt1),
        .drv_en(drv_en), .ld_en(ld_en), .extout_en(extout_en), .busy(busy), .err(err)
    );

    kaipokrandt_bus_ctrl #(.NREG(3), .IW(2)) u3 (
        .clk(clk), .reset(reset),
        .req0(r3), .src0(src0), .dst0(dst0), .ext0(ext0), .gnt0(g3a),
        .req1(1'b0), .src1(2'd0), .dst1(2'd0), .ext1(1'b0), .gnt1(g3b),
        .drv_en(d3), .ld_en(l3), .extout_en(x3), .busy(b3), .err(e3)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        check("drv_onehot", 32'($countones(drv_en) <= 1), 1);
        check("ld_onehot", 32'($countones(ld_en) <= 1), 1);
        check("drv_ld_overlap", 32'(drv_en & ld_en), 0);
        check("gnt_both", 32'(gnt0 & gnt1), 0);
    end

    task automatic run(input bit id, input logic [1:0] s, input logic [1:0] d, input bit e,
                       input logic [3:0] xdrv, input logic [3:0] xld);
        if (id) begin req1 = 1; src1 = s; dst1 = d; ext1 = e; end
        else begin req0 = 1; src0 = s; dst0 = d; ext0 = e; end
        tick();
        check("t1_drv", 32'(drv_en), 32'(xdrv));
        check("t1_ld", 32'(ld_en), 0);
        check("t1_busy", 32'(busy), 1);
        tick();
        check("t2_drv", 32'(drv_en), 32'(xdrv));
        check("t2_ld", 32'(ld_en), 32'(xld));
        tick();
        check("t3_gnt", 32'({gnt1, gnt0}), id ? 2 : 1);
        check("t3_err", 32'(err), 0);
        check("t3_drv", 32'(drv_en | ld_en), 0);
        check("t3_busy", 32'(busy), 1);
        req0 = 0;
        req1 = 0;
        tick();
        check("idle_busy", 32'(busy), 0);
    endtask

    initial begin
        tick();
        tick();
        check("rst_out", 32'({drv_en, ld_en, gnt0, gnt1, err, busy, extout_en}), 0);
        reset = 1;
        tick();
        run(0, 2'd1, 2'd2, 0, 4'b0010, 4'b0100);
        run(1, 2'd3, 2'd0, 1, 4'b1000, 4'b0001);
        check("ext_set", 32'(extout_en), 1);
        run(0, 2'd1, 2'd2, 0, 4'b0010, 4'b0100);
        check("ext_keep", 32'(extout_en), 1);
        run(1, 2'd1, 2'd2, 1, 4'b0010, 4'b0100);
        check("ext_keep2", 32'(extout_en), 1);
        run(0, 2'd2, 2'd0, 0, 4'b0100, 4'b0001);
        check("ext_clr", 32'(extout_en), 0);
        reset = 0;
        tick();
        reset = 1;
        req0 = 1; src0 = 2'd1; dst0 = 2'd2;
        req1 = 1; src1 = 2'd3; dst1 = 2'd0; ext1 = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("rr_drv", 32'(drv_en), (k % 2) ? 32'h8 : 32'h2);
            tick();
            tick();
            check("rr_gnt", 32'({gnt1, gnt0}), (k % 2) ? 2 : 1);
            tick();
            check("rr_idle", 32'(busy), 0);
        end
        req0 = 0;
        req1 = 0;
        tick();
        req1 = 1; src1 = 2'd2; dst1 = 2'd1;
        tick();
        tick();
        check("mid_ld", 32'(ld_en), 32'h2);
        reset = 0;
        req0 = 1; src0 = 2'd1; dst0 = 2'd2;
        tick();
        check("mid_rst", 32'({drv_en, ld_en, gnt0, gnt1, err, busy, extout_en}), 0);
        reset = 1;
        tick();
        check("post_rst_drv", 32'(drv_en), 32'h2);
        tick();
        tick();
        check("post_rst_gnt", 32'({gnt1, gnt0}), 1);
        req0 = 0;
        tick();
        tick();
        check("pend1_drv", 32'(drv_en), 32'h4);
        tick();
        tick();
        check("pend1_gnt", 32'({gnt1, gnt0}), 2);
        req1 = 0;
        tick();
        req0 = 1; src0 = 2'd1; dst0 = 2'd1;
        tick();
        check("inv_gnt", 32'({gnt1, gnt0, err}), 32'b011);
        check("inv_en", 32'({drv_en, ld_en}), 0);
        req0 = 0;
        tick();
        check("inv_idle", 32'({err, busy, drv_en, ld_en}), 0);
        r3 = 1; src0 = 2'd1; dst0 = 2'd3;
        tick();
        check("n3_gnt", 32'({g3b, g3a, e3}), 32'b011);
        check("n3_en", 32'({d3, l3}), 0);
        r3 = 0;
        tick();
        tick();
        req0 = 1; src0 = 2'd1; dst0 = 2'd2;
        tick();
        check("b2b_drv1", 32'(drv_en), 32'h2);
        tick();
        check("b2b_ld1", 32'(ld_en), 32'h4);
        tick();
        check("b2b_gnt1", 32'(gnt0), 1);
        src0 = 2'd2; dst0 = 2'd1;
        tick();
        check("b2b_idle", 32'(busy), 0);
        tick();
        check("b2b_drv2", 32'(drv_en), 32'h4);
        tick();
        check("b2b_ld2", 32'({drv_en, ld_en}), 32'h42);
        tick();
        check("b2b_gnt2", 32'(gnt0), 1);
        req0 = 0;
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/kaipokrandt_bus_ctrl.md
Name: kaipokrandt_bus_ctrl

Overview:
Bus-transfer controller for the shared 16-bit tristate system bus and its bus registers (port0 and peers). It arbitrates between two requesters with round-robin priority and sequences one register-to-register transfer at a time. It generates the one-hot drive enables (to each register's `bus` input), the load strobes (to each `load` input) and the sticky port0 external-output enable. It guarantees that at most one register drives the bus in any cycle.

Parameters:
NREG, 4, number of bus registers on the system bus; register index 0 is port0.
IW, 2, index width; must satisfy 2**IW >= NREG.

Ports:
clk  input  1  system clock, rising-edge.
reset  input  1  synchronous, active-low reset.
req0  input  1  requester 0 transfer request; held high until gnt0.
src0  input  IW  requester 0 source register index.
dst0  input  IW  requester 0 destination register index.
ext0  input  1  requester 0 external-output flag (meaningful only when dst0==0).
gnt0  output  1  one-cycle completion pulse for requester 0.
req1, src1, dst1, ext1, gnt1: same as above, for requester 1.
drv_en  output  NREG  one-hot or zero bus-drive enables, bit i goes to register i `bus`.
ld_en  output  NREG  one-hot or zero load strobes, bit i goes to register i `load`.
extout_en  output  1  port0 `extout`, sticky.
busy  output  1  high whenever state != IDLE.
err  output  1  one-cycle pulse, coincident with gnt, for a rejected transfer.

Behaviour:
- Reset: reset is synchronous and active-low. At the first rising clk edge with reset=0, the block enters IDLE and all outputs go to 0 (drv_en, ld_en, gnt0/1, err, busy, extout_en). The round-robin pointer resets to favour requester 0. Reset mid-transfer aborts with no load issued.
- State machine: IDLE, DRIVE, LOAD, DONE. Outputs are decoded from registered state and latched fields only, with no combinational path from req/src/dst to outputs.
- IDLE:
  - If neither req is high, stay in IDLE.
  - If one req is high, grant that requester.
  - If both are high, grant the requester the pointer favours.
  - On grant, latch the winner's src, dst, ext and id.
  - If the latched request is invalid (src==dst, or src>=NREG, or dst>=NREG), go to DONE with the error flag set. Otherwise go to DRIVE.
- DRIVE: drv_en[src]=1, ld_en=0. This is the bus settle cycle. Go to LOAD.
- LOAD: drv_en[src]=1 and ld_en[dst]=1; the destination captures the bus on the next edge. If dst==0, extout_hold is set to ext at that edge. Go to DONE.
- DONE:
  - gnt of the latched id is 1; err=1 if the error flag is set.
  - drv_en and ld_en are 0.
  - The pointer is updated to favour the other requester.
  - Go to IDLE.
- Latency: req sampled in IDLE at cycle t gives DRIVE at t+1, LOAD at t+2 and gnt at t+3. Four cycles per transfer including IDLE. An error transfer gets gnt+err at t+1 with no enables ever asserted.
- Handshake:
  - The requester holds req/src/dst/ext stable until gnt and drops req on the edge where gnt is sampled.
  - Changes on a non-granted or in-flight request are ignored, because fields are latched in IDLE.
  - Dropping req mid-transfer does not abort.
  - If req is still high in the IDLE after DONE, a new transfer is accepted (back-to-back).
- extout_en follows extout_hold (reset 0). It changes only on a completed non-error transfer with dst==0.
- Invariants: popcount(drv_en)<=1 and popcount(ld_en)<=1 every cycle. ld_en[i] and drv_en[i] are never both high. gnt0 and gnt1 are never both high.
- Starvation: under continuous contention, grants strictly alternate 0,1,0,1.

Test Plan:
- Single transfer: req0=1, src0=1, dst0=2, after reset → drv_en=0010 at t+1; drv_en=0010 and ld_en=0100 at t+2; gnt0 at t+3; busy high t+1..t+3; err=0.
- Port0 external: req1, src1=3, dst1=0, ext1=1 → ld_en=0001 at t+2; extout_en=1 from t+3. A later transfer dst=0, ext=0 clears it. A transfer to dst=2 with ext=1 leaves it unchanged.
- Contention: req0 and req1 both held high continuously → gnt order 0,1,0,1. Each gnt is 4 cycles apart, and drv_en is never multi-hot.
- Invalid request: src0=dst0=1 → gnt0 and err at t+1; drv_en and ld_en stay 0. NREG=3 with dst=3 gives the same result.
- Reset mid-op: assert reset=0 during LOAD → at the next edge all outputs are 0, state is IDLE, and no gnt is issued. A pending req after reset release is granted to requester 0 first.
- Back-to-back: req0 kept high through gnt with src/dst changed to 2→1 → a second transfer starts in the IDLE immediately after DONE, with correct new enables.
